aload_seq: RTL

Load sequencer for a WIDTH-bit register bank built from asynchronous-load flip-flops (arst/rval style cells). It arbitrates round-robin between two requesters that want to force a new value into the bank. It then drives the bank's shared async-load pin and load-value bus with registered, glitch-free waveforms that meet programmable setup, pulse and hold windows. It sits beside the bank and owns every bank async-load control.

---
 rtl/aload_seq.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/aload_seq.sv
// aload_seq -- load sequencer for a bank of asynchronous-load flip-flops.
//
// Two requesters are arbitrated round-robin. The granted value is then forced
// into the bank by driving the shared async-load pin (ff_aload) and the
// load-value bus (ff_rval) through setup, pulse and hold windows. Every output
// comes straight from a flop, so ff_aload cannot glitch.
//
// Ports:
//   clk, arst            clock; asynchronous active-high reset
//   req0/req1, val0/val1 level requests and the values to load (sampled at grant)
//   ack0/ack1            one-cycle completion pulse to the granted requester
//   busy                 high whenever the sequencer is not idle
//   ff_rval, ff_aload    bank load-value bus and async-load pin
//   ff_freeze            bank clock-enable inhibit, SETUP through DONE
//   ff_q                 bank output, only used by readback
//   load_err             readback mismatch pulse, aligned with ack
//
// Optional feature: define ALOAD_SEQ_READBACK_EN to build the readback compare.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; grant edge loads ff_rval
// SETUP | ff_rval settling before the pulse, SETUP_CYC cycles
// PULSE | ff_aload high, PULSE_CYC cycles (also the reset state)
// HOLD  | ff_rval held after the pulse, HOLD_CYC cycles
// DONE  | one cycle; ack to the granted requester, rr pointer update

module aload_seq #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               SETUP_CYC = 1,
    parameter int               PULSE_CYC = 2,
    parameter int               HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] val0,
    input  logic [WIDTH-1:0] val1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic [WIDTH-1:0] ff_rval,
    output logic             ff_aload,
    output logic             ff_freeze,
    input  logic [WIDTH-1:0] ff_q,
    output logic             load_err
);

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_C = CW'(SETUP_CYC);
    localparam logic [CW-1:0] PULSE_C = CW'(PULSE_CYC);
    localparam logic [CW-1:0] HOLD_C  = CW'(HOLD_CYC);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rval_q, rval_d;
    logic             aload_q, aload_d;
    logic             freeze_q, freeze_d;
    logic             busy_q, busy_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             gnt_q, gnt_d;       // index of the granted requester
    logic             rr_q, rr_d;         // 1: requester 1 wins a tie
    logic             rst_seq_q, rst_seq_d; // sequence started by reset, no requester
    logic             err_q, err_d;
    logic             tc;
    logic             pick1;

    assign tc    = (cnt_q == ONE_C);
    assign pick1 = req1 & (~req0 | rr_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rval_d    = rval_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        rst_seq_d = rst_seq_q;

        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_C;
                    gnt_d   = pick1;
                    rval_d  = pick1 ? val1 : val0;
                end
            end
            ST_SETUP: begin
                if (tc) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_C;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            ST_PULSE: begin
                if (tc) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_C;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            ST_HOLD: begin
                if (tc) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                rst_seq_d = 1'b0;
                if (!rst_seq_q) begin
                    rr_d = ~gnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so each flop already holds
        // the value that belongs to the cycle the FSM is entering.
        aload_d  = (state_d == ST_PULSE);
        freeze_d = (state_d != ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
        ack0_d   = (state_d == ST_DONE) && !rst_seq_q && !gnt_q;
        ack1_d   = (state_d == ST_DONE) && !rst_seq_q &&  gnt_q;

`ifdef ALOAD_SEQ_READBACK_EN
        // Compare in HOLD's last cycle so the registered flag lands with ack.
        err_d = (state_q == ST_HOLD) && tc && !rst_seq_q && (ff_q != rval_q);
`else
        err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= ST_PULSE;
            cnt_q     <= PULSE_C;
            rval_q    <= RESET_VAL;
            aload_q   <= 1'b1;
            freeze_q  <= 1'b1;
            busy_q    <= 1'b1;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            gnt_q     <= 1'b0;
            rr_q      <= 1'b0;
            rst_seq_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rval_q    <= rval_d;
            aload_q   <= aload_d;
            freeze_q  <= freeze_d;
            busy_q    <= busy_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            rst_seq_q <= rst_seq_d;
            err_q     <= err_d;
        end
    end

    assign ff_rval   = rval_q;
    assign ff_aload  = aload_q;
    assign ff_freeze = freeze_q;
    assign busy      = busy_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;

`ifdef ALOAD_SEQ_READBACK_EN
    assign load_err = err_q;
`else
    // Without readback the bank output is not observed and the flag stays low.
    logic unused_ff_q;
    logic unused_err;
    assign unused_ff_q = ^ff_q;
    assign unused_err  = err_q;
    assign load_err    = 1'b0;
`endif

endmodule
